// File: rtl/cache_bus_responder.sv
// Memory-backed stand-in for the AXI bridge plus RAM on the cache refill/writeback port.
// Handles one request at a time: word or line reads with fixed latency, and word or line writes with byte strobes.
module cache_bus_responder #(
  parameter int MEM_WORDS  = 16384,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         idle,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  // state    | meaning
  // IDLE     | ready for a read or write handshake
  // RD_WAIT  | read accepted, latency counter running
  // RD_BURST | return beats being issued
  // WR_HOLD  | write committed, holding off the next handshake
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_HOLD} state_t;

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [15:0] RD_RELOAD = 16'(RD_LATENCY - 1);
  localparam logic [15:0] WR_RELOAD = 16'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);

  state_t        state, state_nxt;
  logic [31:0]   mem [MEM_WORDS];
  logic [15:0]   cnt;
  logic [AW-1:0] rd_base;
  logic          rd_line;
  logic [1:0]    beat;
  logic          rd_hs, wr_hs, beat_go;
  logic [AW-1:0] wr_idx;
  logic          unused_addr_bits;

  assign rd_hs   = rd_req && rd_rdy;
  assign wr_hs   = wr_req && wr_rdy;
  assign wr_idx  = wr_addr[AW+1:2];
  assign beat_go = (state == RD_WAIT && cnt == 16'd0) || (state == RD_BURST && !ret_last);
  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_hs) begin
          if (WR_LATENCY > 0) state_nxt = WR_HOLD;
        end else if (rd_hs) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT:  if (cnt == 16'd0) state_nxt = RD_BURST;
      RD_BURST: if (ret_last) state_nxt = IDLE;
      WR_HOLD:  if (cnt == 16'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_rdy = resetn && (state == IDLE);
    rd_rdy = resetn && (state == IDLE) && !wr_req;
    idle   = resetn && (state == IDLE);
  end

  // Latency down-counter, read capture and registered return beats
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      rd_base   <= '0;
      rd_line   <= 1'b0;
      beat      <= '0;
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= '0;
      if (wr_hs) begin
        wr_count <= wr_count + 32'd1;
        cnt      <= WR_RELOAD;
      end else if (rd_hs) begin
        rd_count <= rd_count + 32'd1;
        cnt      <= RD_RELOAD;
        rd_line  <= (rd_type == 3'b100);
        rd_base  <= (rd_type == 3'b100) ? {rd_addr[AW+1:4], 2'b00} : rd_addr[AW+1:2];
        beat     <= '0;
      end else if ((state == RD_WAIT || state == WR_HOLD) && cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end
      if (beat_go) begin
        ret_valid <= 1'b1;
        ret_data  <= mem[rd_base + AW'(beat)];
        ret_last  <= !rd_line || (beat == 2'd3);
        beat      <= beat + 2'd1;
      end
    end
  end

  // Backing store is never reset; writes commit on the handshake edge
  always_ff @(posedge clock) begin
    if (wr_hs) begin
      if (wr_type == 3'b100) begin
        for (int i = 0; i < 4; i++)
          mem[{wr_idx[AW-1:2], 2'(i)}] <= wr_data[32*i +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (wr_wstrb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/cache_bus_responder.md
# cache_bus_responder

Memory-backed responder for the cache-side refill/writeback interface (rd_req/ret_*/wr_req). It sits where the AXI bridge normally sits and stands in for the bridge plus RAM, so a single icache or dcache can be tested without AXI. It serves one request at a time: word or cache-line reads with programmable latency, and word or line writes with byte strobes.

## Interface
- MEM_WORDS, 16384: backing store depth in 32-bit words; power of two.
- RD_LATENCY, 2: cycles from read acceptance to first ret beat; must be ≥1.
- WR_LATENCY, 1: busy cycles after a write is accepted; must be ≥0.
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request.
- rd_type  in  3  000 byte, 001 half, 010 word, 100 line (4 words); other codes are treated as 010.
- rd_addr  in  32  byte address.
- rd_rdy  out  1  read accepted when rd_req && rd_rdy.
- ret_valid  out  1  return beat valid; no back-pressure.
- ret_last  out  1  final beat of a response.
- ret_data  out  32  return word.
- wr_req  in  1  write request.
- wr_type  in  3  same encoding as rd_type.
- wr_addr  in  32  byte address.
- wr_wstrb  in  4  byte enables for non-line writes.
- wr_data  in  128  line data; word i is [32i+31:32i]; non-line writes use [31:0].
- wr_rdy  out  1  write accepted when wr_req && wr_rdy.
- idle  out  1  high in IDLE with no response pending.
- rd_count  out  32  accepted reads, wraps at 2^32.
- wr_count  out  32  accepted writes, wraps at 2^32.

## Operation
- Word index: addr[log2(MEM_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo the depth.
- States and transitions:
  - IDLE → RD_WAIT on a read handshake.
  - IDLE → WR_HOLD on a write handshake when WR_LATENCY > 0.
  - RD_WAIT → RD_BURST when the latency counter expires.
  - RD_BURST → IDLE after the last beat.
  - WR_HOLD → IDLE after WR_LATENCY cycles.
- Handshake outputs:
  - wr_rdy = resetn && state==IDLE.
  - rd_rdy = resetn && state==IDLE && !wr_req.
  - If both requests arrive in IDLE, the write wins; the read waits.
- Requests are captured on the handshake edge (type, address and beat count). Request inputs are ignored outside IDLE.
- Non-line read: one beat containing the full aligned word at rd_addr, with ret_last=1. The cache extracts the byte or halfword.
- Line read: 4 beats, words base..base+3 where base = word index with bits[1:0] cleared (addr[3:2] ignored). Beats go out on consecutive cycles, and ret_last is set on beat 3.
- Line write: all 4 words of the aligned line are written at full width; wr_wstrb is ignored.
- Non-line write: only the bytes enabled in wr_wstrb are written at the addressed word. wstrb=0 updates nothing but still counts as a handshake.
- Writes commit on the handshake edge. A read accepted on a later cycle always sees the new data.
- rd_count and wr_count increment on the handshake edge.
- Memory contents are not reset; the bench preloads them hierarchically.

## Timing
- Reset (resetn low, asynchronous):
  - state=IDLE; counters=0.
  - ret_valid=0, ret_last=0, ret_data=0.
  - rd_rdy=0, wr_rdy=0, idle=0.
  - An in-flight burst is aborted and no further beats are issued.
- Read accepted at edge T: first ret_valid in the cycle after edge T+RD_LATENCY. A line read then stays valid for 4 consecutive cycles.
- ret_data and ret_last are registered, and are 0 whenever ret_valid=0.
- Next handshake (either direction), earliest:
  - after a read: the cycle following ret_last.
  - after a write with WR_LATENCY=0: the very next cycle.
  - after a write with WR_LATENCY=N>0: accepted WR_LATENCY cycles after the edge that accepted the write.
- idle = state==IDLE.

## Test plan
- Line read, RD_LATENCY=2, mem[0x40..0x43]=A0..A3, rd_addr=0x108 type 100 at edge T:
  - ret_valid in cycles T+2..T+5 with data A0,A1,A2,A3.
  - ret_last only at T+5; rd_rdy=0 throughout; rd_count=1.
- Byte write then word read: wr_addr=0x20, wstrb=0010, data=0x0000AB00 over old word 0x11223344; next cycle read type 000 at 0x21 → single beat 0x1122AB44 with ret_last=1.
- Simultaneous requests in IDLE: wr_rdy=1 and rd_rdy=0, so the write is accepted first. The read is accepted WR_LATENCY+1 cycles later and returns the newly written line; wr_count=1, rd_count=1.
- Line write of 0xDDDD_CCCC_BBBB_AAAA_… at 0x3000C: wstrb=0000 is ignored, and a subsequent line read at 0x30000 returns all 4 written words in order.
- Reset mid-burst: drop resetn after beat 1 of a line read. ret_valid falls immediately, no beats 2-3 appear, counters=0; after release, rd_rdy=1 in IDLE.
- Address wrap: with MEM_WORDS=16384, read 0x0001_0004 → returns mem[1].
